// File: rtl/t_est_pkg.sv
// Shared types and constants for the temperature-rate integrator.
package t_est_pkg;

  localparam int DATA_W    = 8;   // Q7.0 sample / temperature width
  localparam int ACC_W     = 16;  // Q8.7 accumulator width
  localparam int FRAC_W    = 7;   // fraction bits in the accumulator
  localparam int K_MAX_DEF = 7;   // default ceiling on the rate-divide shift

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HOLD
  } state_t;

endpackage

// File: rtl/t_int_sat.sv
// Clamps a 17-bit signed sum into a 16-bit [lo, hi] window and reports
// whether the clamp was applied.
module t_int_sat
  import t_est_pkg::*;
(
  input  logic signed [ACC_W:0]   din,
  input  logic signed [ACC_W-1:0] lo,
  input  logic signed [ACC_W-1:0] hi,
  output logic signed [ACC_W-1:0] dout,
  output logic                    clamped
);

  logic signed [ACC_W:0] lo_x;
  logic signed [ACC_W:0] hi_x;

  assign lo_x = {lo[ACC_W-1], lo};
  assign hi_x = {hi[ACC_W-1], hi};

  // Pass the sum through unless it falls outside the window.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first,
    // otherwise an unassigned path infers a latch.
    dout    = din[ACC_W-1:0];
    clamped = 1'b0;
    if (din < lo_x) begin
      dout    = lo;
      clamped = 1'b1;
    end else if (din > hi_x) begin
      dout    = hi;
      clamped = 1'b1;
    end
  end

endmodule

// File: rtl/t_integrator.sv
// Rate-sample integrator: accumulates scaled dT samples into a Q8.7
// temperature, clamps to [t_min, t_max] and presents the integer part on a
// valid/ready output with full throughput.
// Optional build macro: T_INTEGRATOR_ROUND_EN selects round-half-up for T_out
// instead of floor.
module t_integrator
  import t_est_pkg::*;
#(
  parameter int K_MAX = K_MAX_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     init,
  input  logic signed [DATA_W-1:0] T_init,
  input  logic signed [DATA_W-1:0] dT_in,
  input  logic                     dt_valid,
  output logic                     dt_ready,
  input  logic        [DATA_W-1:0] k_int,
  input  logic signed [DATA_W-1:0] t_min,
  input  logic signed [DATA_W-1:0] t_max,
  output logic signed [DATA_W-1:0] T_out,
  output logic                     t_valid,
  input  logic                     t_ready,
  output logic                     sat
);

  localparam int EXT_W = ACC_W - DATA_W - FRAC_W;

  state_t                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q;
  logic                     in_xfer, out_xfer;
  logic        [DATA_W-1:0] k_eff;
  logic signed [ACC_W-1:0]  dt_scaled, step;
  logic signed [ACC_W:0]    sum, init_scaled, sat_din;
  logic signed [ACC_W-1:0]  lo_b, hi_init, hi_run, sat_hi;
  logic signed [ACC_W-1:0]  acc_next;
  logic                     clamp_hit;
  logic signed [DATA_W+1:0] q_raw, tmin_x, tmax_x;
  logic signed [DATA_W-1:0] tout_d;

  assign in_xfer  = dt_valid && dt_ready;
  assign out_xfer = t_valid && t_ready;

  // Shift is capped at K_MAX; the sample is widened to Q8.7 before shifting
  // so the arithmetic shift keeps the fractional bits.
  assign k_eff     = (k_int > DATA_W'(K_MAX)) ? DATA_W'(K_MAX) : k_int;
  assign dt_scaled = {{EXT_W{dT_in[DATA_W-1]}}, dT_in, {FRAC_W{1'b0}}};
  assign step      = dt_scaled >>> k_eff;
  assign sum       = {acc_q[ACC_W-1], acc_q} + {step[ACC_W-1], step};

  // Init loads T_init clamped to whole degrees; a running sum may reach the
  // top of the t_max degree (fraction all ones).
  assign init_scaled = {{(EXT_W+1){T_init[DATA_W-1]}}, T_init, {FRAC_W{1'b0}}};
  assign lo_b        = {{EXT_W{t_min[DATA_W-1]}}, t_min, {FRAC_W{1'b0}}};
  assign hi_init     = {{EXT_W{t_max[DATA_W-1]}}, t_max, {FRAC_W{1'b0}}};
  assign hi_run      = {{EXT_W{t_max[DATA_W-1]}}, t_max, {FRAC_W{1'b1}}};

  // One clamp unit shared between init and accumulate; init has priority.
  assign sat_din = init ? init_scaled : sum;
  assign sat_hi  = init ? hi_init : hi_run;

  t_int_sat u_sat (
    .din     (sat_din),
    .lo      (lo_b),
    .hi      (sat_hi),
    .dout    (acc_next),
    .clamped (clamp_hit)
  );

`ifdef T_INTEGRATOR_ROUND_EN
  // Round half up: floor plus the half-LSB bit.
  assign q_raw = {acc_next[ACC_W-1], acc_next[ACC_W-1:FRAC_W]}
               + {{(DATA_W+1){1'b0}}, acc_next[FRAC_W-1]};
`else
  assign q_raw = {acc_next[ACC_W-1], acc_next[ACC_W-1:FRAC_W]};
`endif

  assign tmin_x = {{2{t_min[DATA_W-1]}}, t_min};
  assign tmax_x = {{2{t_max[DATA_W-1]}}, t_max};

  // Output clamp; since t_max <= 127 it also saturates a rounded +128.
  always_comb begin
    tout_d = q_raw[DATA_W-1:0];
    if (q_raw < tmin_x) begin
      tout_d = t_min;
    end else if (q_raw > tmax_x) begin
      tout_d = t_max;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and dt_ready; input is refused while an output is stalled.
  always_comb begin
    state_d  = state_q;
    dt_ready = 1'b0;
    case (state_q)
      IDLE: begin
        if (init) state_d = RUN;
      end
      RUN: begin
        dt_ready = !t_valid || t_ready;
        if (!init && t_valid && !t_ready) state_d = HOLD;
      end
      HOLD: begin
        if (init || t_ready) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  // Accumulator, output register and sticky clamp flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q   <= '0;
      T_out   <= '0;
      t_valid <= 1'b0;
      sat     <= 1'b0;
    end else if (init) begin
      acc_q   <= acc_next;
      t_valid <= 1'b0;
      sat     <= 1'b0;
    end else if (in_xfer) begin
      acc_q   <= acc_next;
      T_out   <= tout_d;
      t_valid <= 1'b1;
      sat     <= sat | clamp_hit;
    end else if (out_xfer) begin
      t_valid <= 1'b0;
    end
  end

endmodule

// File: doc/t_integrator.md
T_INTEGRATOR -- requirements
Module: t_integrator

Interface
REQ-001 Parameter K_MAX, default 7, is the maximum effective rate-divide shift.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 init  input  1  load T_init into the accumulator and restart the trajectory.
REQ-005 T_init  input  8  signed Q7.0 start temperature.
REQ-006 dT_in  input  8  signed Q7.0 rate sample.
REQ-007 dt_valid  input  1  dT_in valid.
REQ-008 dt_ready  output  1  block accepts dT_in.
REQ-009 k_int  input  8  rate divide shift; values above K_MAX are treated as K_MAX.
REQ-010 t_min  input  8  signed Q7.0 lower output clamp.
REQ-011 t_max  input  8  signed Q7.0 upper output clamp; the bench guarantees t_min <= t_max.
REQ-012 T_out  output  8  signed Q7.0 reconstructed temperature.
REQ-013 t_valid  output  1  T_out valid.
REQ-014 t_ready  input  1  downstream accepts T_out.
REQ-015 sat  output  1  sticky flag: a clamp occurred since the last init.

Function
REQ-016 FSM states: IDLE, RUN, HOLD.
- IDLE (after reset): dt_ready=0; init moves to RUN.
- RUN: dt_ready=1.
- HOLD: entered when t_valid=1 and t_ready=0; dt_ready=0.
REQ-017 Input transfer: dt_valid && dt_ready at a posedge.
REQ-018 Output transfer: t_valid && t_ready at a posedge.
REQ-019 Accumulator acc is signed 16-bit Q8.7.
REQ-020 On init: acc = T_init<<7, clamped to [t_min<<7, t_max<<7]; sat cleared; t_valid=0; state=RUN.
REQ-021 init takes priority over a simultaneous input transfer; that sample is dropped.
REQ-022 On an input transfer: step = (dT_in<<<7)>>>min(k_int,K_MAX), arithmetic shift; sum = acc + step, computed at 17 bits.
REQ-023 The sum is clamped to [t_min<<7, (t_max<<7)+127].
- Any clamp sets sat.
- acc takes the clamped value.
REQ-024 T_out = acc>>>7 (floor), registered, with t_valid=1 on the posedge after the input transfer (latency 1).
REQ-025 Exception to REQ-024: T_out is not allowed below t_min or above t_max.
REQ-026 When an output transfer coincides with a new input transfer, T_out and t_valid=1 update in the same cycle (full throughput).
REQ-027 When an output transfer occurs with no new input, t_valid falls to 0.
REQ-028 In HOLD, T_out and t_valid are stable until t_ready=1; state then returns to RUN.
REQ-029 Changing k_int, t_min or t_max mid-run takes effect on the next input transfer; acc is not re-clamped retroactively.

Reset
REQ-030 While rst=1, asynchronously:
- state=IDLE, acc=0.
- T_out=0, t_valid=0, sat=0, dt_ready=0.
REQ-031 Reset mid-HOLD discards the pending output.
REQ-032 After reset release, the block waits for init before accepting any dT.

Configuration
REQ-033 With T_INTEGRATOR_ROUND_EN defined:
- T_OUT = (acc+64)>>>7, round-half-up.
- The result saturates to 127.
- The clamp to [t_min, t_max] still applies.
REQ-034 Without T_INTEGRATOR_ROUND_EN, T_out uses floor per REQ-024.

Structure
REQ-035 Package t_est_pkg holds:
- the FSM state enum;
- the Q8.7 width constant (16);
- the fraction-bit constant (7);
- the K_MAX default.
REQ-036 Sub-module t_int_sat performs the 17-bit to 16-bit clamp and generates the clamp flag; it is instantiated once.

Verification
REQ-037 Reset, then init with T_init=0, k_int=3, t_min=-128, t_max=127; dT_in=40 for 3 transfers -> T_out=5, 10, 15; sat=0.
REQ-038 Same stimulus as REQ-037 with t_max=12 -> T_out=5, 10, 12; sat=1 and it stays 1 until the next init.
REQ-039 Init with T_init=0, k_int=3, one dT_in=-1 -> acc=-16.
- Without macro: T_out=-1.
- With T_INTEGRATOR_ROUND_EN: T_out=0.
REQ-040 Hold t_ready=0 for 4 cycles after a valid output -> T_out stable, dt_ready=0; when t_ready returns to 1, the next sample is accepted.
REQ-041 init with dt_valid=1 in the same cycle, T_init=20 -> t_valid=0; the next transfer with dT_in=8, k_int=3 gives T_out=21.
REQ-042 k_int=200, dT_in=-128 from T_init=0 -> step=-128 (shift=7), T_out=-1 per transfer; no overflow across 130 transfers; T_out=-128 with sat=1 at the floor.
